// File: rtl/pmu_readout_ctrl.sv
// Purpose : arbitrates the PMU counter-bank read port between host single reads and a
//           periodic 16-counter telemetry sweep; emits (index, value, source) records.
// Latency : host handshake N -> PMU strobe N+1 -> record valid N+3 (N+2+TIMEOUT on timeout).
// Backpr. : a record holds out_valid and all fields until out_ready; no new PMU read is
//           issued while a record is pending, and sweep triggers arriving then are dropped.
// Ports   : clk/rst (sync, active-high); host_req_* (valid/ready request, index);
//           sweep_enable; pmu_register/valid_pmu_register (read strobe), pmu_value/valid_value
//           (read data); out_* (record stream); sweep_overrun (dropped trigger); busy.
module pmu_readout_ctrl #(
  parameter int COUNTERSIZE   = 8,
  parameter int REGISTER_SIZE = 4,
  parameter int SWEEP_PERIOD  = 1000,
  parameter int TIMEOUT       = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     host_req_valid,
  input  logic [REGISTER_SIZE-1:0] host_req_index,
  output logic                     host_req_ready,
  input  logic                     sweep_enable,
  output logic [REGISTER_SIZE-1:0] pmu_register,
  output logic                     valid_pmu_register,
  input  logic [COUNTERSIZE-1:0]   pmu_value,
  input  logic                     valid_value,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [REGISTER_SIZE-1:0] out_index,
  output logic [COUNTERSIZE-1:0]   out_value,
  output logic                     out_source,
  output logic                     out_last,
  output logic                     out_error,
  output logic                     sweep_overrun,
  output logic                     busy
);

  localparam int PW = (SWEEP_PERIOD > 1) ? $clog2(SWEEP_PERIOD) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [PW-1:0]            PERIOD_LAST  = PW'(SWEEP_PERIOD - 1);
  localparam logic [TW-1:0]            TIMEOUT_LAST = TW'(TIMEOUT - 1);
  localparam logic [REGISTER_SIZE-1:0] LAST_IDX     = {REGISTER_SIZE{1'b1}};

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, OUTPUT} state_t;

  state_t                   state_q, state_d;
  logic [REGISTER_SIZE-1:0] idx_q, idx_d;          // index of the read in flight
  logic                     src_q, src_d;          // 0 = host, 1 = sweep
  logic                     strobe_q, strobe_d;
  logic [TW-1:0]            tmo_q, tmo_d;
  logic                     out_valid_q, out_valid_d;
  logic [REGISTER_SIZE-1:0] out_index_q, out_index_d;
  logic [COUNTERSIZE-1:0]   out_value_q, out_value_d;
  logic                     out_source_q, out_source_d;
  logic                     out_last_q, out_last_d;
  logic                     out_error_q, out_error_d;
  logic [REGISTER_SIZE-1:0] sweep_idx_q, sweep_idx_d;
  logic                     sweep_active_q, sweep_active_d;
  logic                     pending_q, pending_d;
  logic [PW-1:0]            period_q, period_d;
  logic                     overrun_q, overrun_d;
  logic                     busy_q, busy_d;
  logic                     trigger;

  assign trigger = sweep_enable && (period_q == PERIOD_LAST);

  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    src_d          = src_q;
    strobe_d       = 1'b0;
    tmo_d          = tmo_q;
    out_valid_d    = out_valid_q;
    out_index_d    = out_index_q;
    out_value_d    = out_value_q;
    out_source_d   = out_source_q;
    out_last_d     = out_last_q;
    out_error_d    = out_error_q;
    sweep_idx_d    = sweep_idx_q;
    sweep_active_d = sweep_active_q;
    pending_d      = pending_q;
    overrun_d      = 1'b0;

    // Period counter and trigger bookkeeping.
    if (!sweep_enable) begin
      period_d  = '0;
      pending_d = 1'b0;
    end else if (trigger) begin
      period_d = '0;
      if (!sweep_active_q && !pending_q) pending_d = 1'b1;
      else                               overrun_d = 1'b1;
    end else begin
      period_d = period_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (host_req_valid) begin
          idx_d    = host_req_index;
          src_d    = 1'b0;
          strobe_d = 1'b1;
          state_d  = ISSUE;
        end else if (sweep_active_q || (pending_q && sweep_enable)) begin
          // Consuming pending here overrides a same-cycle trigger, which was
          // already counted as an overrun above since pending_q was set.
          pending_d      = 1'b0;
          sweep_active_d = 1'b1;
          idx_d          = sweep_idx_q;
          src_d          = 1'b1;
          strobe_d       = 1'b1;
          state_d        = ISSUE;
        end
      end
      ISSUE: begin
        tmo_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (valid_value || (tmo_q == TIMEOUT_LAST)) begin
          out_value_d  = valid_value ? pmu_value : '0;
          out_error_d  = !valid_value;
          out_valid_d  = 1'b1;
          out_index_d  = idx_q;
          out_source_d = src_q;
          out_last_d   = src_q && (idx_q == LAST_IDX);
          state_d      = OUTPUT;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      OUTPUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
          if (src_q) begin
            sweep_idx_d = sweep_idx_q + 1'b1;   // wraps to 0 after the last index
            if (sweep_idx_q == LAST_IDX) sweep_active_d = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE) || sweep_active_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      idx_q          <= '0;
      src_q          <= 1'b0;
      strobe_q       <= 1'b0;
      tmo_q          <= '0;
      out_valid_q    <= 1'b0;
      out_index_q    <= '0;
      out_value_q    <= '0;
      out_source_q   <= 1'b0;
      out_last_q     <= 1'b0;
      out_error_q    <= 1'b0;
      sweep_idx_q    <= '0;
      sweep_active_q <= 1'b0;
      pending_q      <= 1'b0;
      period_q       <= '0;
      overrun_q      <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      src_q          <= src_d;
      strobe_q       <= strobe_d;
      tmo_q          <= tmo_d;
      out_valid_q    <= out_valid_d;
      out_index_q    <= out_index_d;
      out_value_q    <= out_value_d;
      out_source_q   <= out_source_d;
      out_last_q     <= out_last_d;
      out_error_q    <= out_error_d;
      sweep_idx_q    <= sweep_idx_d;
      sweep_active_q <= sweep_active_d;
      pending_q      <= pending_d;
      period_q       <= period_d;
      overrun_q      <= overrun_d;
      busy_q         <= busy_d;
    end
  end

  assign host_req_ready     = (state_q == IDLE) && !rst;
  assign pmu_register       = idx_q;
  assign valid_pmu_register = strobe_q;
  assign out_valid          = out_valid_q;
  assign out_index          = out_index_q;
  assign out_value          = out_value_q;
  assign out_source         = out_source_q;
  assign out_last           = out_last_q;
  assign out_error          = out_error_q;
  assign sweep_overrun      = overrun_q;
  assign busy               = busy_q;

endmodule

// File: tb/tb_pmu_readout_ctrl.sv
module tb_pmu_readout_ctrl;
  localparam int CS = 8;
  localparam int RS = 4;
  localparam int SP = 100;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          host_req_valid;
  logic [RS-1:0] host_req_index;
  logic          host_req_ready;
  logic          sweep_enable;
  logic [RS-1:0] pmu_register;
  logic          valid_pmu_register;
  logic [CS-1:0] pmu_value = '0;
  logic          valid_value = 1'b0;
  logic          out_valid;
  logic          out_ready;
  logic [RS-1:0] out_index;
  logic [CS-1:0] out_value;
  logic          out_source;
  logic          out_last;
  logic          out_error;
  logic          sweep_overrun;
  logic          busy;

  int checks   = 0;
  int failures = 0;
  int cycle    = 0;
  logic [CS-1:0] mem [16];
  logic          pmu_drop;

  pmu_readout_ctrl #(.COUNTERSIZE(CS), .REGISTER_SIZE(RS), .SWEEP_PERIOD(SP), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .host_req_valid(host_req_valid), .host_req_index(host_req_index), .host_req_ready(host_req_ready),
    .sweep_enable(sweep_enable),
    .pmu_register(pmu_register), .valid_pmu_register(valid_pmu_register),
    .pmu_value(pmu_value), .valid_value(valid_value),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_index(out_index), .out_value(out_value), .out_source(out_source),
    .out_last(out_last), .out_error(out_error),
    .sweep_overrun(sweep_overrun), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  // PMU model: answers one cycle after the strobe unless told to stay silent.
  always @(posedge clk) begin
    valid_value <= 1'b0;
    if (valid_pmu_register && !pmu_drop) begin
      valid_value <= 1'b1;
      pmu_value   <= mem[pmu_register];
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic bound_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s: got timeout required event", name);
  endtask

  task automatic wait_strobe(output int t);
    int n = 0;
    while (!valid_pmu_register && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!valid_pmu_register) bound_fail("wait_strobe");
    t = cycle;
  endtask

  // Waits for a record, samples it, optionally raises a host request while the
  // record is still in OUTPUT, then steps past the handshake (out_ready is high).
  task automatic get_rec(input logic ins_host, output logic [RS-1:0] idx, output logic [CS-1:0] val,
                         output logic src, output logic last, output logic err, output int t);
    int n = 0;
    while (!out_valid && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) bound_fail("wait_record");
    idx  = out_index;
    val  = out_value;
    src  = out_source;
    last = out_last;
    err  = out_error;
    t    = cycle;
    if (ins_host) begin
      host_req_valid = 1'b1;
      host_req_index = 4'd2;
    end
    @(negedge clk);
  endtask

  typedef struct {
    logic [RS-1:0] idx;
    logic          drop;
    logic [CS-1:0] exp_val;
    logic          exp_err;
    int            exp_lat;
  } vec_t;

  vec_t vt[6];

  initial begin
    logic [RS-1:0] ri;
    logic [CS-1:0] rv;
    logic rs, rl, re;
    int t, t_en, t_first, t_last, lat, bad, ovr, ovr_t, n;

    for (int i = 0; i < 16; i++) mem[i] = 8'(i * 17 + 3);
    mem[5] = 8'h2A;

    // idx, drop, expected value, expected error, cycles from handshake to out_valid
    vt[0] = '{4'd5,  1'b0, 8'h2A, 1'b0, 3};
    vt[1] = '{4'd0,  1'b0, 8'h03, 1'b0, 3};
    vt[2] = '{4'd15, 1'b0, 8'h02, 1'b0, 3};
    vt[3] = '{4'd9,  1'b1, 8'h00, 1'b1, 2 + TO};
    vt[4] = '{4'd9,  1'b0, 8'h9C, 1'b0, 3};
    vt[5] = '{4'd12, 1'b0, 8'hCF, 1'b0, 3};

    rst = 1'b1; host_req_valid = 1'b0; host_req_index = '0;
    sweep_enable = 1'b0; out_ready = 1'b1; pmu_drop = 1'b0;

    // ---------------- reset ----------------
    @(negedge clk);
    chk("rst_ready_low", 32'(host_req_ready), 32'd0);
    @(negedge clk);
    chk("rst_strobe", 32'(valid_pmu_register), 32'd0);
    chk("rst_pmu_reg", 32'(pmu_register), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_fields", {out_index, out_value, out_source, out_last, out_error}, 32'd0);
    chk("rst_overrun", 32'(sweep_overrun), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    #1;
    chk("ready_after_rst", 32'(host_req_ready), 32'd1);
    @(negedge clk);

    // ---------------- host reads (table) ----------------
    for (int i = 0; i < 6; i++) begin
      pmu_drop       = vt[i].drop;
      host_req_valid = 1'b1;
      host_req_index = vt[i].idx;
      chk("host_ready", 32'(host_req_ready), 32'd1);
      @(negedge clk);
      host_req_valid = 1'b0;
      chk("host_strobe", 32'(valid_pmu_register), 32'd1);
      chk("host_pmu_reg", 32'(pmu_register), 32'(vt[i].idx));
      chk("host_busy", 32'(busy), 32'd1);
      lat = 1;
      while (!out_valid && lat < 20) begin
        @(negedge clk);
        lat++;
      end
      chk("host_latency", 32'(lat), 32'(vt[i].exp_lat));
      chk("host_index", 32'(out_index), 32'(vt[i].idx));
      chk("host_value", 32'(out_value), 32'(vt[i].exp_val));
      chk("host_source", 32'(out_source), 32'd0);
      chk("host_last", 32'(out_last), 32'd0);
      chk("host_error", 32'(out_error), 32'(vt[i].exp_err));
      @(negedge clk);
      chk("host_consumed", 32'(out_valid), 32'd0);
      pmu_drop = 1'b0;
    end

    // ---------------- sweep 1: timing and full content ----------------
    sweep_enable = 1'b1;
    t_en = cycle;
    wait_strobe(t);
    // trigger when period counter hits 99, pending next cycle, strobe the cycle after
    chk("sweep1_start", 32'(t - t_en), 32'd101);
    t_first = 0; t_last = 0;
    for (int r = 0; r < 16; r++) begin
      get_rec(1'b0, ri, rv, rs, rl, re, t);
      if (r == 0) t_first = t;
      if (r == 15) t_last = t;
      chk("sweep1_index", 32'(ri), 32'(r));
      chk("sweep1_value", 32'(rv), 32'(mem[r]));
      chk("sweep1_source", 32'(rs), 32'd1);
      chk("sweep1_last", 32'(rl), (r == 15) ? 32'd1 : 32'd0);
      chk("sweep1_error", 32'(re), 32'd0);
    end
    chk("sweep1_duration", 32'(t_last - t_first), 32'd60);
    chk("sweep1_idle_busy", 32'(busy), 32'd0);

    // ---------------- sweep 2: host inserted after index 7 ----------------
    wait_strobe(t);
    chk("sweep2_start", 32'(t - t_en), 32'd201);
    for (int r = 0; r < 8; r++) begin
      get_rec(r == 7, ri, rv, rs, rl, re, t);
      chk("sweep2_index", 32'(ri), 32'(r));
    end
    chk("insert_ready", 32'(host_req_ready), 32'd1);
    @(negedge clk);
    host_req_valid = 1'b0;
    get_rec(1'b0, ri, rv, rs, rl, re, t);
    chk("insert_index", 32'(ri), 32'd2);
    chk("insert_source", 32'(rs), 32'd0);
    chk("insert_value", 32'(rv), 32'h25);
    for (int r = 8; r < 16; r++) begin
      get_rec(1'b0, ri, rv, rs, rl, re, t);
      chk("resume_index", 32'(ri), 32'(r));
      chk("resume_source", 32'(rs), 32'd1);
      chk("resume_last", 32'(rl), (r == 15) ? 32'd1 : 32'd0);
    end

    // ---------------- sweep 3: stalled consumer, overruns ----------------
    out_ready = 1'b0;
    n = 0;
    while (!out_valid && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) bound_fail("stall_record");
    chk("stall_index", 32'(out_index), 32'd0);
    bad = 0; ovr = 0; ovr_t = 0;
    for (int k = 0; k < 240; k++) begin
      @(negedge clk);
      if (!out_valid || out_index != 4'd0 || out_source != 1'b1 || valid_pmu_register) bad++;
      if (sweep_overrun) begin
        ovr++;
        if (ovr == 1) ovr_t = cycle - t_en;
      end
    end
    chk("stall_stable", 32'(bad), 32'd0);
    chk("overrun_count", 32'(ovr), 32'd2);
    chk("overrun_first_at", 32'(ovr_t), 32'd400);
    sweep_enable = 1'b0;
    out_ready    = 1'b1;
    @(negedge clk);
    for (int r = 1; r < 16; r++) begin
      get_rec(1'b0, ri, rv, rs, rl, re, t);
      chk("drain_index", 32'(ri), 32'(r));
    end
    chk("drain_busy", 32'(busy), 32'd0);
    n = 0;
    for (int k = 0; k < 150; k++) begin
      @(negedge clk);
      if (valid_pmu_register) n++;
    end
    chk("disabled_no_sweep", 32'(n), 32'd0);

    // ---------------- reset during WAIT ----------------
    sweep_enable = 1'b1;
    for (int r = 0; r < 5; r++) begin
      get_rec(1'b0, ri, rv, rs, rl, re, t);
      chk("pre_rst_index", 32'(ri), 32'(r));
    end
    wait_strobe(t);
    chk("pre_rst_pmu_reg", 32'(pmu_register), 32'd5);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("wrst_out_valid", 32'(out_valid), 32'd0);
    chk("wrst_strobe", 32'(valid_pmu_register), 32'd0);
    chk("wrst_pmu_reg", 32'(pmu_register), 32'd0);
    chk("wrst_fields", {out_index, out_value, out_source, out_last, out_error}, 32'd0);
    chk("wrst_busy", 32'(busy), 32'd0);
    chk("wrst_ready", 32'(host_req_ready), 32'd0);
    rst = 1'b0;
    n = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (out_valid) n++;
    end
    chk("wrst_no_record", 32'(n), 32'd0);
    get_rec(1'b0, ri, rv, rs, rl, re, t);
    chk("restart_index", 32'(ri), 32'd0);
    chk("restart_source", 32'(rs), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
